// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter state encoding
//               and the serial data width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Serial data width in bits (8N1 framing)
    localparam int UART_DW = 8;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input bit.
//               Both flops reset to RST_VAL so the output is defined (and
//               matches the line's idle level) straight out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver. Start bit confirmed at
//               mid-bit, data/stop sampled every OVERSAMPLE ticks after
//               that. Good bytes go to a one-entry valid/ready holding
//               register; framing and overrun errors are one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_tick,
    output logic [UART_DW-1:0] rx_data,
    output logic               rx_vld,
    input  logic               rx_rdy,
    output logic               rx_ferr,
    output logic               rx_ovr,
    output logic               rx_busy,
    input  logic               RX
);

    localparam int                c_CNT_W   = $clog2(OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]         c_LAST_BIT = 3'(UART_DW - 1);

    logic                w_rxs;

    uart_state_t         r_state;
    uart_state_t         w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]          r_bit_i;
    logic [2:0]          w_bit_nxt;
    logic [UART_DW-1:0]  r_shreg;
    logic [UART_DW-1:0]  w_shreg_nxt;
    logic                w_stop_ok;
    logic                w_stop_bad;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .i_d (RX),
        .o_q (w_rxs)
    );

    // Frame tracking: everything advances only on rx_tick, otherwise holds
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_i;
        w_shreg_nxt = r_shreg;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        if (rx_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end
                end
                START: begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_HALF_M1) begin
                        w_cnt_nxt = '0;
                        if (!w_rxs) begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch
                            w_state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_FULL_M1) begin
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = {w_rxs, r_shreg[UART_DW-1:1]};
                        if (r_bit_i == c_LAST_BIT) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_nxt = r_bit_i + 3'd1;
                        end
                    end
                end
                STOP: begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_FULL_M1) begin
                        w_cnt_nxt = '0;
                        if (w_rxs) begin
                            w_stop_ok   = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            // Wait for the line to recover so a held-low
                            // break does not re-trigger every bit time
                            w_stop_bad  = 1'b1;
                            w_state_nxt = BRK;
                        end
                    end
                end
                BRK: begin
                    if (w_rxs) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Frame-tracking state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit_i <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit_i <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Holding register and error pulses; a delivery may reuse a slot that
    // is being drained in the very same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            rx_ferr <= w_stop_bad;
            rx_ovr  <= w_stop_ok & rx_vld & ~rx_rdy;
            if (w_stop_ok && (!rx_vld || rx_rdy)) begin
                rx_data <= r_shreg;
                rx_vld  <= 1'b1;
            end else if (rx_vld && rx_rdy) begin
                rx_vld  <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the design's `uart_tx`. It shares the same external baud-tick source, runs at `OVERSAMPLE` ticks per bit, and frames 8N1 (start, 8 data LSB-first, 1 stop). It resynchronises the asynchronous `RX` pin, validates the start bit at mid-bit, and checks the stop bit. Each good byte is presented through a one-entry valid/ready holding register; framing and overrun errors are reported as one-cycle pulses.

## Interface
- `OVERSAMPLE`, default 16: `rx_tick` pulses per bit period; even, ≥4.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_tick`  in  1  one-cycle strobe at `OVERSAMPLE`×baud; sampling advances only on it.
- `rx_data`  out  8  received byte; stable while `rx_vld`=1.
- `rx_vld`  out  1  holding register full.
- `rx_rdy`  in  1  consumer accepts; transfer when `rx_vld & rx_rdy`.
- `rx_ferr`  out  1  one-cycle pulse: stop bit sampled 0.
- `rx_ovr`  out  1  one-cycle pulse: byte completed while holding register full and not draining.
- `rx_busy`  out  1  high in any state except IDLE.
- `RX`  in  1  asynchronous serial line; idle high.

## Operation
- `RX` passes through a 2-FF synchroniser; its registers reset to 1. All decisions use the synchronised value `rxs`.
- Counters:
  - `cnt` has width $clog2(OVERSAMPLE) and advances only on `rx_tick`.
  - `bit_i` is 3 bits.
  - `shreg` is 8 bits; it shifts right with the new bit entering the MSB, so after 8 bits `shreg[0]` is the first bit received.
- FSM states:
  - IDLE: on tick with `rxs`=0, go to START with `cnt`=0.
  - START: on tick, `cnt++`. At `cnt`==OVERSAMPLE/2−1:
    - `rxs`=0: go to DATA with `cnt`=0 and `bit_i`=0.
    - `rxs`=1: glitch; return to IDLE with no output.
  - DATA: on tick, `cnt++`. At `cnt`==OVERSAMPLE−1, sample `rxs` into `shreg` and set `cnt`=0. If `bit_i`==7 go to STOP, else `bit_i++`.
  - STOP: on tick at `cnt`==OVERSAMPLE−1, sample `rxs`:
    - 1: deliver the byte and go to IDLE.
    - 0: pulse `rx_ferr`, discard the byte, go to BRK.
  - BRK: on tick with `rxs`=1, go to IDLE. This prevents a held-low line from re-triggering continuously.
- Delivery, evaluated in the cycle after the stop sample:
  - `rx_vld`=0, or `rx_vld & rx_rdy` in the same cycle: load `rx_data`, `rx_vld`=1.
  - Otherwise: the new byte is dropped, `rx_ovr` pulses, and the held `rx_data` is unchanged.
- Handshake: `rx_vld & rx_rdy` with no delivery that cycle clears `rx_vld` next cycle. `rx_rdy` while `rx_vld`=0 has no effect.
- Reset at any time, including mid-frame: return to IDLE and discard the partial byte.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_vld`=0, `rx_ferr`=0, `rx_ovr`=0, `rx_busy`=0.
  - Synchroniser registers = 1; `cnt`=0, `bit_i`=0, `shreg`=0.
- Input latency: an `RX` edge reaches `rxs` 2 clk later.
- Sample points:
  - Start is confirmed OVERSAMPLE/2 ticks after detection.
  - Each data and stop bit is sampled OVERSAMPLE ticks after the previous sample point, which is nominal mid-bit.
- `rx_vld` rises 1 clk after the stop-sample tick. `rx_ferr` and `rx_ovr` are asserted in that same clk, for exactly one cycle.
- `rx_busy` rises 1 clk after the detection tick and falls 1 clk after the exit tick.
- Back-to-back frames: the stop sample returns the FSM to IDLE, so a start edge from the next tick onward is detected. This tolerates a stop bit only ½ bit long.
- If `rx_tick` is absent, state is held.

## Structure
- `uart_pkg`: the state enum `{IDLE, START, DATA, STOP, BRK}` and the `UART_DW=8` constant. Share it with `uart_tx` on the next revision.
- Sub-module `sync_2ff` (parameter `RST_VAL`), used for `RX`. Everything else lives in `uart_rx`.

## Test plan
All scenarios use OVERSAMPLE=16 and `rx_tick` every 4 clk; the bench model drives bits 64 clk wide.
- Send 0xA5 with `rx_rdy`=1 → `rx_vld` pulses 1 cycle with `rx_data`=0xA5; `rx_ferr`=`rx_ovr`=0; `rx_busy` is high for about 9.5 bit periods.
- Send 0x3C, then 0xC3 back-to-back with a ½-bit stop, `rx_rdy`=0 → 0x3C is held, `rx_ovr` pulses once at the 0xC3 stop, and `rx_data` stays 0x3C. Then assert `rx_rdy` → one transfer, `rx_vld`=0.
- Drive `RX` low for 20 clk (shorter than ½ bit), then high → FSM returns to IDLE, no `rx_vld`, no `rx_ferr`.
- Send 0x55 with the stop bit forced 0 and the line held low for 3 bits → `rx_ferr` pulses once, no `rx_vld`, no re-detection until the line goes high. A following 0x0F is received correctly.
- Assert `rst` for 1 cycle at data bit 4 of 0xFF → outputs at reset values next cycle. The remainder of the frame is ignored until a genuine start: the trailing 1s never produce a start. A subsequent 0x81 is received correctly.
- Same-cycle case: complete 0x12 while 0x34 is held and `rx_rdy`=1 in the delivery cycle → `rx_data`=0x12, `rx_vld` stays 1, `rx_ovr`=0.
